// File: rtl/control_part4_pkg.sv
// Shared constants and state encodings for the part4 matrix-vector sequencer.
// Contents: dimension/width localparams and the FSM state codes.
// The FSM codes are plain logic constants so older tooling can read the state.
package control_part4_pkg;

  localparam int N        = 8;
  localparam int DATA_W   = 14;
  localparam int ACC_W    = 28;
  localparam int ADDR_X_W = 3;
  localparam int ADDR_W_W = 6;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_LOAD_X = 3'd2;
  localparam logic [2:0] ST_CLEAR  = 3'd3;
  localparam logic [2:0] ST_MAC    = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_OUT    = 3'd6;

endpackage

// File: rtl/control_part4_if.sv
// Host-side handshakes of control_part4: input word stream and result stream.
// Ports: s_valid/s_ready/s_data (words in), out_valid/out_ready/out_row (results out).
// master = host/stimulus side, slave = control_part4 side.
interface control_part4_if;
  import control_part4_pkg::*;

  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_X_W-1:0]      out_row;

  modport master (
    output s_valid, s_data, out_ready,
    input  s_ready, out_valid, out_row
  );

  modport slave (
    input  s_valid, s_data, out_ready,
    output s_ready, out_valid, out_row
  );

endinterface

// File: rtl/control_part4.sv
// Sequencer for datapath_part4: loads W (8x8) and X (8) from a word stream, then runs one 8-term MAC per row.
// Ports: clk/rst_n, start/load_w command, stream+result handshakes via control_part4_if.slave,
//   datapath controls (input_data, addr_x/wr_en_x, addr_w/wr_en_w, clear_acc, en_acc), busy, w_loaded.
// Latency: start of CLEAR to out_valid is 10 cycles; out_ready low holds OUT (accumulator untouched).
module control_part4
  import control_part4_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       load_w,
  control_part4_if.slave             s,
  output logic signed [DATA_W-1:0]   input_data,
  output logic [ADDR_X_W-1:0]        addr_x,
  output logic                       wr_en_x,
  output logic [ADDR_W_W-1:0]        addr_w,
  output logic                       wr_en_w,
  output logic                       clear_acc,
  output logic                       en_acc,
  output logic                       busy,
  output logic                       w_loaded
);

  state_t                state_q;
  logic [ADDR_W_W-1:0]   cnt_q;
  logic [ADDR_X_W-1:0]   row_q;
  logic                  en_acc_q;
  logic                  w_loaded_q;

  logic in_load_w, in_load_x, in_mac, accept;

  assign in_load_w = (state_q == ST_LOAD_W);
  assign in_load_x = (state_q == ST_LOAD_X);
  assign in_mac    = (state_q == ST_MAC);

  assign s.s_ready = in_load_w | in_load_x;
  assign accept    = s.s_valid & s.s_ready;

  assign input_data = s.s_data;
  assign wr_en_w    = in_load_w & s.s_valid;
  assign wr_en_x    = in_load_x & s.s_valid;

  // In MAC the W address only carries the row; the datapath forms the
  // column from addr_x, so both memories are indexed by the same term k.
  assign addr_w = in_load_w ? cnt_q :
                  in_mac    ? {row_q, 3'b000} : '0;
  assign addr_x = (in_load_x | in_mac) ? cnt_q[ADDR_X_W-1:0] : '0;

  assign clear_acc   = (state_q == ST_CLEAR);
  // The datapath registers its product select, so the accumulate enable
  // trails the MAC address phase by one cycle; DRAIN picks up term 7.
  assign en_acc      = en_acc_q;
  assign s.out_valid = (state_q == ST_OUT);
  assign s.out_row   = row_q;
  assign busy        = (state_q != ST_IDLE);
  assign w_loaded    = w_loaded_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      en_acc_q   <= 1'b0;
      w_loaded_q <= 1'b0;
    end else begin
      en_acc_q <= in_mac;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            if (load_w || !w_loaded_q) begin
              state_q    <= ST_LOAD_W;
              // A partial reload leaves W inconsistent until all 64 words land.
              w_loaded_q <= 1'b0;
            end else begin
              state_q <= ST_LOAD_X;
            end
          end
        end
        ST_LOAD_W: begin
          if (accept) begin
            if (cnt_q == 6'd63) begin
              cnt_q      <= '0;
              w_loaded_q <= 1'b1;
              state_q    <= ST_LOAD_X;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        ST_LOAD_X: begin
          if (accept) begin
            if (cnt_q[2:0] == 3'd7) begin
              cnt_q   <= '0;
              row_q   <= '0;
              state_q <= ST_CLEAR;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        ST_CLEAR: begin
          cnt_q   <= '0;
          state_q <= ST_MAC;
        end
        ST_MAC: begin
          if (cnt_q[2:0] == 3'd7) begin
            cnt_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          if (s.out_ready) begin
            if (row_q == 3'd7) begin
              state_q <= ST_IDLE;
            end else begin
              row_q   <= row_q + 3'd1;
              state_q <= ST_CLEAR;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_part4.sv
// Bench for control_part4 with a behavioural datapath_part4 (W/X memories, registered select, saturating accumulate).
// Directed runs: identity, stalled output, saturation, W reuse, gapped W load, reset mid-MAC.
// Expected Y values are hand-computed constants per run.
module tb_control_part4;
  import control_part4_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start, load_w;
  logic signed [13:0] input_data;
  logic [2:0] addr_x;
  logic [5:0] addr_w;
  logic wr_en_x, wr_en_w, clear_acc, en_acc, busy, w_loaded;

  control_part4_if bus();

  control_part4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_w(load_w), .s(bus),
    .input_data(input_data), .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_w(addr_w), .wr_en_w(wr_en_w), .clear_acc(clear_acc), .en_acc(en_acc),
    .busy(busy), .w_loaded(w_loaded)
  );

  // ---------------- behavioural datapath ----------------
  logic signed [13:0] wmem [64];
  logic signed [13:0] xmem [8];
  logic [5:0]         sel_q;
  logic signed [27:0] acc, prod, w_ext, x_ext, acc_nxt;
  logic signed [28:0] sum;

  assign w_ext = 28'(wmem[sel_q]);
  assign x_ext = 28'(xmem[sel_q[2:0]]);
  assign prod  = w_ext * x_ext;

  always_comb begin
    sum = {acc[27], acc} + {prod[27], prod};
    if (sum[28] != sum[27]) acc_nxt = sum[28] ? 28'h8000000 : 28'h7FFFFFF;
    else                    acc_nxt = sum[27:0];
  end

  always @(posedge clk) begin
    if (wr_en_w) wmem[addr_w] <= input_data;
    if (wr_en_x) xmem[addr_x] <= input_data;
    sel_q <= {addr_w[5:3], addr_x};
    if (clear_acc)   acc <= '0;
    else if (en_acc) acc <= acc_nxt;
  end

  // ---------------- monitors ----------------
  int cyc = 0, clr_cyc = 0, n_acc = 0, bad_wr = 0, bad_ce = 0;
  int wlog [$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (wr_en_w && !(bus.s_valid && bus.s_ready)) bad_wr++;
    if (wr_en_x && !(bus.s_valid && bus.s_ready)) bad_wr++;
    if (clear_acc && en_acc) bad_ce++;
    if (bus.s_valid && bus.s_ready) n_acc++;
    if (wr_en_w) wlog.push_back(int'(addr_w));
    if (clear_acc) clr_cyc = cyc;
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic signed [13:0] wv [64];
  logic signed [13:0] xv [8];
  int ye [8];

  task automatic start_cmd(input logic lw);
    start = 1'b1; load_w = lw;
    tick();
    start = 1'b0; load_w = 1'b0;
  endtask

  task automatic send(input logic signed [13:0] d, input int gap);
    int t;
    t = 0;
    bus.s_valid = 1'b1; bus.s_data = d;
    while (!bus.s_ready && t < 50) begin tick(); t++; end
    if (!bus.s_ready) chk("s_ready_timeout", 0, 1);
    tick();
    bus.s_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_words(input logic with_w, input int gap);
    if (with_w) for (int k = 0; k < 64; k++) send(wv[k], gap);
    for (int i = 0; i < 8; i++) send(xv[i], gap);
  endtask

  // Collect nrows results; stall>0 holds out_ready low that many cycles in OUT.
  task automatic collect(input string nm, input int nrows, input int stall);
    int t;
    int held;
    for (int r = 0; r < nrows; r++) begin
      t = 0;
      bus.out_ready = (stall == 0);
      while (!bus.out_valid && t < 100) begin tick(); t++; end
      if (!bus.out_valid) chk({nm, "_out_timeout"}, 0, 1);
      chk({nm, "_lat"}, cyc - clr_cyc, 10);
      chk({nm, "_row"}, int'(bus.out_row), r);
      chk({nm, "_y"}, int'(acc), ye[r]);
      if (stall > 0) begin
        held = int'(acc);
        repeat (stall) tick();
        chk({nm, "_stall_vld"}, int'(bus.out_valid), 1);
        chk({nm, "_stall_y"}, int'(acc), held);
        bus.out_ready = 1'b1;
      end
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    int base;
    int bad;
    rst_n = 1'b0; start = 1'b0; load_w = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_w_loaded", int'(w_loaded), 0);
    chk("rst_s_ready", int'(bus.s_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_clear_en", int'({clear_acc, en_acc, wr_en_w, wr_en_x}), 0);
    chk("rst_addr", int'({addr_w, addr_x}), 0);
    rst_n = 1'b1;
    tick();

    // Test 1: W = identity, X = 1..8 -> Y[r] = r+1
    for (int k = 0; k < 64; k++) wv[k] = (k / 8 == k % 8) ? 14'sd1 : 14'sd0;
    for (int i = 0; i < 8; i++) begin xv[i] = 14'(i + 1); ye[i] = i + 1; end
    start_cmd(1'b1);
    chk("t1_busy", int'(busy), 1);
    send_words(1'b1, 0);
    chk("t1_w_loaded", int'(w_loaded), 1);
    collect("t1", 8, 0);
    chk("t1_idle", int'(busy), 0);

    // Test 4: reuse identity W, X = all 1 -> Y[r] = 1, only 8 words consumed
    for (int i = 0; i < 8; i++) begin xv[i] = 14'sd1; ye[i] = 1; end
    base = n_acc;
    start_cmd(1'b0);
    send_words(1'b0, 0);
    chk("t4_words", n_acc - base, 8);
    collect("t4", 8, 0);

    // Test 2: W all 2, X all -3, output stalled 5 cycles per row; start mid-run ignored
    for (int k = 0; k < 64; k++) wv[k] = 14'sd2;
    for (int i = 0; i < 8; i++) begin xv[i] = -14'sd3; ye[i] = -48; end
    start_cmd(1'b1);
    send_words(1'b1, 0);
    start_cmd(1'b1);
    collect("t2", 8, 5);

    // Test 3: everything -8192 -> 8 * 2^26 saturates at 2^27-1
    for (int k = 0; k < 64; k++) wv[k] = -14'sd8192;
    for (int i = 0; i < 8; i++) begin xv[i] = -14'sd8192; ye[i] = 134217727; end
    start_cmd(1'b1);
    send_words(1'b1, 0);
    collect("t3", 8, 0);

    // Test 5: gapped W load, W[k] = k, X all 1 -> Y[r] = 64r + 28
    for (int k = 0; k < 64; k++) wv[k] = 14'(k);
    for (int i = 0; i < 8; i++) begin xv[i] = 14'sd1; ye[i] = 64 * i + 28; end
    wlog.delete();
    start_cmd(1'b1);
    send_words(1'b1, 1);
    chk("t5_wr_count", wlog.size(), 64);
    bad = 0;
    for (int k = 0; k < wlog.size(); k++) if (wlog[k] != k) bad++;
    chk("t5_wr_order", bad, 0);
    collect("t5", 8, 0);

    // Test 6: W all 1, X 1..8 (Y = 36), reset during MAC of row 3
    for (int k = 0; k < 64; k++) wv[k] = 14'sd1;
    for (int i = 0; i < 8; i++) begin xv[i] = 14'(i + 1); ye[i] = 36; end
    start_cmd(1'b1);
    send_words(1'b1, 0);
    collect("t6a", 3, 0);
    repeat (4) tick();
    chk("t6_in_mac", int'(en_acc), 1);
    rst_n = 1'b0;
    tick();
    chk("t6_busy", int'(busy), 0);
    chk("t6_w_loaded", int'(w_loaded), 0);
    chk("t6_ctrl", int'({clear_acc, en_acc, wr_en_w, wr_en_x, bus.s_ready, bus.out_valid}), 0);
    chk("t6_addr", int'({addr_w, addr_x, bus.out_row}), 0);
    rst_n = 1'b1;
    tick();
    // W is gone, so load_w=0 must still take the full W load.
    for (int k = 0; k < 64; k++) wv[k] = (k / 8 == k % 8) ? 14'sd1 : 14'sd0;
    for (int i = 0; i < 8; i++) begin xv[i] = 14'(i + 1); ye[i] = i + 1; end
    base = n_acc;
    start_cmd(1'b0);
    send_words(1'b1, 0);
    chk("t6_words", n_acc - base, 72);
    chk("t6_w_reloaded", int'(w_loaded), 1);
    collect("t6b", 8, 0);

    chk("illegal_writes", bad_wr, 0);
    chk("clear_and_en", bad_ce, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
